fetch_buffer: RTL

Dual-ported circular instruction queue between the fetch stage and the decode stage. Accepts up to two fetched instructions per cycle from IF and presents the two oldest entries as decode slots a and b. It retires 0, 1 or 2 entries per cycle according to decode's consume count. It decouples fetch stalls from decode and is cleared on pipeline flush (branch mispredict, exception, ertn).

---
 rtl/fetch_buffer_pkg.sv | 25 ++
 rtl/fetch_buffer.sv | 85 ++++++++
 2 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared IF/ID definitions: exception codes and the fetched-instruction record
// carried through the fetch buffer and across the IF/ID boundary.
package fetch_buffer_pkg;

    typedef enum logic [3:0] {
        EXC_NONE = 4'd0,
        EXC_ADEF = 4'd1,
        EXC_TLBR = 4'd2,
        EXC_PIF  = 4'd3,
        EXC_PPI  = 4'd4,
        EXC_INE  = 4'd5,
        EXC_SYS  = 4'd6,
        EXC_BRK  = 4'd7
    } exception_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_branch_taken;
        logic [31:0] pred_branch_target;
        logic        have_exception;
        exception_t  exception_type;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular IF->ID instruction queue: up to 2 pushes and 2 pops per cycle,
// two oldest entries presented as decode slots a and b.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in0_valid,
    input  fetch_entry_t               in0_entry,
    input  logic                       in1_valid,
    input  fetch_entry_t               in1_entry,
    output logic                       fb_allowin,
    input  logic [1:0]                 consume,
    output logic                       a_valid,
    output fetch_entry_t               a_entry,
    output logic                       b_valid,
    output fetch_entry_t               b_entry,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic [1:0]    n_push, n_pop;

    // Registered count only, so decode's consume never reaches fetch combinationally.
    assign fb_allowin = count_q <= CW'(DEPTH - 2);

    always_comb begin
        n_push = 2'd0;
        if (fb_allowin && in0_valid)
            n_push = in1_valid ? 2'd2 : 2'd1;
        n_pop = (consume == 2'd3) ? 2'd2 : consume;
        if (CW'(n_pop) > count_q)
            n_pop = count_q[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(n_pop);
            tail_q  <= tail_q + PW'(n_push);
            count_q <= count_q + CW'(n_push) - CW'(n_pop);
        end
    end

    // Storage carries no reset; only slots being pushed are written.
    always_ff @(posedge clk) begin
        if (!reset && !flush && n_push != 2'd0) begin
            mem[tail_q] <= in0_entry;
            if (n_push == 2'd2)
                mem[tail_q + PW'(1)] <= in1_entry;
        end
    end

    assign count   = count_q;
    assign a_valid = count_q != '0;
    assign b_valid = count_q >= CW'(2);
    assign a_entry = mem[head_q];
    assign b_entry = mem[head_q + PW'(1)];

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && !flush) begin
            assert ({{(CW-2){1'b0}}, consume} <= count_q);
            assert (!(in1_valid && !in0_valid));
            assert (!(in0_valid && !fb_allowin));
        end
    end
`endif

endmodule
